// File: rtl/qea_run_sequencer.sv
// Sequences one QEA emulation run: context load, state init, start/execute, state readout.
// Optional run watchdog enabled by defining QEA_SEQ_TIMEOUT_EN.
module qea_run_sequencer #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int RD_LATENCY              = 1,
  parameter int CYC_CNT_WIDTH           = 32
`ifdef QEA_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES          = 2**24
`endif
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_run,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
  input  logic                                 i_ctx_valid,
  output logic                                 o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_word,
  output logic                                 o_rd_valid,
  input  logic                                 i_rd_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
  output logic                                 o_rd_last,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_error,
  output logic [CYC_CNT_WIDTH-1:0]             o_exec_cycles,
  output logic                                 q_start,
  output logic [MAX_QBIT_WIDTH-1:0]            q_qbit_num,
  output logic                                 q_ctx_en,
  output logic                                 q_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   q_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   q_ctx_data,
  output logic [PE_NUM-1:0]                    q_state_ena,
  output logic [PE_NUM-1:0]                    q_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          q_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   q_state_dina,
  input  logic                                 q_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   q_state_dout
);

  localparam int WORD_W = PE_NUM * STATE_DATA_WIDTH;
  localparam int INS_W  = GATE_CONTEXT_ADDR_WIDTH + 1;
  localparam logic [INS_W-1:0]          MAX_INS   = {1'b1, {GATE_CONTEXT_ADDR_WIDTH{1'b0}}};
  localparam logic [MAX_QBIT_WIDTH-1:0] MIN_QBIT  = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  localparam logic [MAX_QBIT_WIDTH-1:0] MAX_QBIT  = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);
  localparam logic [DATA_WIDTH-1:0]     ONE_RE    = DATA_WIDTH'(1) << NUM_FRAC_BIT;
  // |0...0>: amplitude 1.0 in the real half of the MSB lane (PE0) of word 0
  localparam logic [WORD_W-1:0]         INIT_WORD = {ONE_RE, {(WORD_W - DATA_WIDTH){1'b0}}};
  localparam logic [1:0]                LAST_WAIT = 2'(RD_LATENCY - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_CTX, S_INIT_STATE, S_INIT_GAP, S_START,
    S_RUN, S_READ_REQ, S_READ_WAIT, S_READ_OUT, S_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [MAX_QBIT_WIDTH-1:0]     qbit_q, qbit_d;
  logic [INS_W-1:0]              ins_q, ins_d;
  logic [INS_W-1:0]              ctx_cnt_q, ctx_cnt_d;
  logic [STATE_ADDR_WIDTH-1:0]   last_q, last_d;
  logic [STATE_ADDR_WIDTH-1:0]   k_q, k_d;
  logic [1:0]                    wait_q, wait_d;
  logic [CYC_CNT_WIDTH-1:0]      cyc_q, cyc_d;
  logic [CYC_CNT_WIDTH-1:0]      exec_q, exec_d;
  logic                          error_q, error_d;
  logic [WORD_W-1:0]             rd_data_q, rd_data_d;
  logic                          ctx_en_q, ctx_en_d;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_addr_q, ctx_addr_d;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_q, ctx_data_d;

  logic [MAX_QBIT_WIDTH-1:0]     shamt;
  logic [STATE_ADDR_WIDTH-1:0]   last_addr;
  logic                          run_legal;
  logic [CYC_CNT_WIDTH-1:0]      cyc_inc;

  assign shamt     = i_qbit_num - MIN_QBIT;
  // D-1 as a low-bit mask, so the full 2**STATE_ADDR_WIDTH depth needs no extra bit
  assign last_addr = ~({STATE_ADDR_WIDTH{1'b1}} << shamt);
  assign run_legal = (i_qbit_num > MIN_QBIT) && (i_qbit_num <= MAX_QBIT) &&
                     (i_ins_num != '0) && (i_ins_num <= MAX_INS);
  assign cyc_inc   = (&cyc_q) ? cyc_q : cyc_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    qbit_d     = qbit_q;
    ins_d      = ins_q;
    ctx_cnt_d  = ctx_cnt_q;
    last_d     = last_q;
    k_d        = k_q;
    wait_d     = wait_q;
    cyc_d      = cyc_q;
    exec_d     = exec_q;
    error_d    = error_q;
    rd_data_d  = rd_data_q;
    ctx_en_d   = 1'b0;
    ctx_addr_d = ctx_addr_q;
    ctx_data_d = ctx_data_q;
    o_ctx_ready   = 1'b0;
    o_rd_valid    = 1'b0;
    o_rd_last     = 1'b0;
    o_done        = 1'b0;
    q_start       = 1'b0;
    q_state_ena   = '0;
    q_state_wea   = '0;
    q_state_addra = '0;
    q_state_dina  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (i_run) begin
          if (run_legal) begin
            qbit_d    = i_qbit_num;
            ins_d     = i_ins_num;
            last_d    = last_addr;
            ctx_cnt_d = '0;
            error_d   = 1'b0;
            state_d   = S_LOAD_CTX;
          end else begin
            error_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_LOAD_CTX: begin
        o_ctx_ready = 1'b1;
        if (i_ctx_valid) begin
          ctx_en_d   = 1'b1;
          ctx_addr_d = ctx_cnt_q[GATE_CONTEXT_ADDR_WIDTH-1:0];
          ctx_data_d = i_ctx_word;
          ctx_cnt_d  = ctx_cnt_q + 1'b1;
          if (ctx_cnt_q + 1'b1 == ins_q) begin
            k_d     = '0;
            state_d = S_INIT_STATE;
          end
        end
      end
      S_INIT_STATE: begin
        q_state_ena   = '1;
        q_state_wea   = '1;
        q_state_addra = k_q;
        q_state_dina  = (k_q == '0) ? INIT_WORD : '0;
        if (k_q == last_q) state_d = S_INIT_GAP;
        else               k_d     = k_q + 1'b1;
      end
      S_INIT_GAP: state_d = S_START;
      S_START: begin
        q_start = 1'b1;
        cyc_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cyc_d = cyc_inc;
        if (q_complete) begin
          exec_d  = cyc_inc;
          k_d     = '0;
          state_d = S_READ_REQ;
        end
`ifdef QEA_SEQ_TIMEOUT_EN
        else if (cyc_inc == CYC_CNT_WIDTH'(TIMEOUT_CYCLES)) begin
          exec_d  = cyc_inc;
          error_d = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      S_READ_REQ: begin
        q_state_ena   = '1;
        q_state_addra = k_q;
        wait_d        = '0;
        state_d       = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        if (wait_q == LAST_WAIT) begin
          rd_data_d = q_state_dout;
          state_d   = S_READ_OUT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_READ_OUT: begin
        o_rd_valid = 1'b1;
        o_rd_last  = (k_q == last_q);
        if (i_rd_ready) begin
          if (k_q == last_q) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = S_READ_REQ;
          end
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      qbit_q     <= '0;
      ins_q      <= '0;
      ctx_cnt_q  <= '0;
      last_q     <= '0;
      k_q        <= '0;
      wait_q     <= '0;
      cyc_q      <= '0;
      exec_q     <= '0;
      error_q    <= 1'b0;
      rd_data_q  <= '0;
      ctx_en_q   <= 1'b0;
      ctx_addr_q <= '0;
      ctx_data_q <= '0;
    end else begin
      state_q    <= state_d;
      qbit_q     <= qbit_d;
      ins_q      <= ins_d;
      ctx_cnt_q  <= ctx_cnt_d;
      last_q     <= last_d;
      k_q        <= k_d;
      wait_q     <= wait_d;
      cyc_q      <= cyc_d;
      exec_q     <= exec_d;
      error_q    <= error_d;
      rd_data_q  <= rd_data_d;
      ctx_en_q   <= ctx_en_d;
      ctx_addr_q <= ctx_addr_d;
      ctx_data_q <= ctx_data_d;
    end
  end

  assign o_busy        = (state_q != S_IDLE);
  assign o_error       = error_q;
  assign o_exec_cycles = exec_q;
  assign o_rd_data     = rd_data_q;
  assign q_qbit_num    = qbit_q;
  assign q_ctx_en      = ctx_en_q;
  assign q_ctx_wea     = ctx_en_q;
  assign q_ctx_addr    = ctx_addr_q;
  assign q_ctx_data    = ctx_data_q;

endmodule

// File: tb/tb_qea_run_sequencer.sv
// Testbench for qea_run_sequencer: a behavioural QEA stub (context log, state RAM,
// completion timer) plus a host model with random valid gaps and readout backpressure.
module tb_qea_run_sequencer;

   localparam logic [255:0] INIT0 = {32'h4000_0000, 224'h0};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_run;
   logic [5:0]   i_qbit_num;
   logic [16:0]  i_ins_num;
   logic         i_ctx_valid;
   logic         o_ctx_ready;
   logic [63:0]  i_ctx_word;
   logic         o_rd_valid;
   logic         i_rd_ready;
   logic [255:0] o_rd_data;
   logic         o_rd_last;
   logic         o_busy;
   logic         o_done;
   logic         o_error;
   logic [31:0]  o_exec_cycles;
   logic         q_start;
   logic [5:0]   q_qbit_num;
   logic         q_ctx_en;
   logic         q_ctx_wea;
   logic [15:0]  q_ctx_addr;
   logic [63:0]  q_ctx_data;
   logic [3:0]   q_state_ena;
   logic [3:0]   q_state_wea;
   logic [15:0]  q_state_addra;
   logic [255:0] q_state_dina;
   logic         q_complete = 1'b0;
   logic [255:0] q_state_dout = '0;

   always #5 clk = ~clk;

   qea_run_sequencer dut (
      .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_qbit_num(i_qbit_num),
      .i_ins_num(i_ins_num), .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready),
      .i_ctx_word(i_ctx_word), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
      .o_rd_data(o_rd_data), .o_rd_last(o_rd_last), .o_busy(o_busy), .o_done(o_done),
      .o_error(o_error), .o_exec_cycles(o_exec_cycles), .q_start(q_start),
      .q_qbit_num(q_qbit_num), .q_ctx_en(q_ctx_en), .q_ctx_wea(q_ctx_wea),
      .q_ctx_addr(q_ctx_addr), .q_ctx_data(q_ctx_data), .q_state_ena(q_state_ena),
      .q_state_wea(q_state_wea), .q_state_addra(q_state_addra),
      .q_state_dina(q_state_dina), .q_complete(q_complete), .q_state_dout(q_state_dout)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: host words offered, what the QEA stub saw, what readout must return
   logic [63:0]  words[$];
   logic [15:0]  ctx_addr_log[$];
   logic [63:0]  ctx_data_log[$];
   logic [255:0] exp_rd[$];
   logic [255:0] mem [0:1023];
   logic [255:0] fill_w;
   int cur_depth = 0;
   int exec_len = 0;
   int init_writes = 0;
   int init_bad = 0;
   int start_cnt = 0;
   int done_cnt = 0;
   int activity = 0;
   int run_n = 0;
   bit running = 1'b0;
   int prev_qbit = 0;

   task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // QEA stub: logs context writes, models the state RAM with one cycle read latency,
   // verifies |0..0> at start, then "executes" by scrambling the state and completing
   // exec_len cycles after q_start.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 1024; i++) mem[i] = {8{32'hDEADBEEF}};
         running = 1'b0;
         q_complete <= 1'b0;
      end else begin
         if (q_ctx_en || q_ctx_wea || (|q_state_ena) || (|q_state_wea) || q_start) activity++;
         if (q_ctx_en && q_ctx_wea) begin
            ctx_addr_log.push_back(q_ctx_addr);
            ctx_data_log.push_back(q_ctx_data);
         end
         if (q_state_ena == 4'hF && q_state_wea == 4'hF) begin
            mem[q_state_addra[9:0]] = q_state_dina;
            init_writes++;
         end
         if (q_state_ena == 4'hF && q_state_wea == 4'h0) q_state_dout <= mem[q_state_addra[9:0]];
         if (o_done) done_cnt++;
         if (q_start) begin
            start_cnt++;
            init_bad = 0;
            for (int i = 0; i < cur_depth; i++)
               if (mem[i] !== ((i == 0) ? INIT0 : 256'h0)) init_bad++;
            for (int i = 0; i < cur_depth; i++) begin
               for (int j = 0; j < 8; j++) fill_w[j*32 +: 32] = $urandom;
               mem[i] = fill_w;
               exp_rd.push_back(fill_w);
            end
            run_n = 1;
            running = 1'b1;
            q_complete <= (exec_len == 1);
         end else if (running) begin
            run_n++;
            q_complete <= (run_n == exec_len);
            if (run_n == exec_len) running = 1'b0;
         end else begin
            q_complete <= 1'b0;
         end
      end
   end

   task automatic applyStimulus(input int qbit, input int ins);
      @(negedge clk);
      i_qbit_num = 6'(qbit);
      i_ins_num  = 17'(ins);
      i_run      = 1'b1;
      @(negedge clk);
      i_run      = 1'b0;
   endtask

   task automatic feedCtx(input int ins, input int vpct, output int acc);
      acc = 0;
      for (int c = 0; c < ins * 30 + 100 && acc < ins; c++) begin
         i_ctx_valid = ($urandom_range(0, 99) < vpct);
         i_ctx_word  = words[acc];
         if (i_ctx_valid && o_ctx_ready) acc++;
         @(negedge clk);
      end
      i_ctx_valid = 1'b0;
   endtask

   task automatic clearRun(input int qbit, input int ins, input int exec);
      cur_depth = 1 << (qbit - 2);
      exec_len  = exec;
      words.delete();
      ctx_addr_log.delete();
      ctx_data_log.delete();
      exp_rd.delete();
      init_writes = 0;
      init_bad    = 0;
      start_cnt   = 0;
      done_cnt    = 0;
      for (int i = 0; i < ins; i++) words.push_back({$urandom, $urandom});
   endtask

   task automatic runLegal(input int qbit, input int ins, input int exec, input int vpct, input int rpct);
      int d, acc, idx, bad_data, bad_stable, bad_last, bad_ctx;
      bit stalled;
      logic [255:0] held;
      clearRun(qbit, ins, exec);
      d = cur_depth;
      applyStimulus(qbit, ins);
      feedCtx(ins, vpct, acc);
      checkOutput("ctx_accepted", acc, ins);
      idx = 0; bad_data = 0; bad_stable = 0; bad_last = 0; stalled = 1'b0; held = '0;
      for (int c = 0; c < exec + d * 40 + 2000 && idx < d; c++) begin
         i_rd_ready = ($urandom_range(0, 99) < rpct);
         if (o_rd_valid) begin
            if (stalled && o_rd_data !== held) bad_stable++;
            if (o_rd_last !== (idx == d - 1)) bad_last++;
            if (i_rd_ready) begin
               if (idx >= exp_rd.size() || o_rd_data !== exp_rd[idx]) bad_data++;
               idx++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held = o_rd_data;
            end
         end
         @(negedge clk);
      end
      i_rd_ready = 1'b0;
      for (int c = 0; c < 20 && done_cnt == 0; c++) @(negedge clk);
      repeat (2) @(negedge clk);
      bad_ctx = 0;
      foreach (ctx_addr_log[i])
         if (i >= ins || ctx_addr_log[i] !== 16'(i) || ctx_data_log[i] !== words[i]) bad_ctx++;
      checkOutput("ctx_writes", ctx_addr_log.size(), ins);
      checkOutput("ctx_order", bad_ctx, 0);
      checkOutput("init_writes", init_writes, d);
      checkOutput("init_content", init_bad, 0);
      checkOutput("start_pulses", start_cnt, 1);
      checkOutput("exec_cycles", o_exec_cycles, exec);
      checkOutput("rd_count", idx, d);
      checkOutput("rd_data", bad_data, 0);
      checkOutput("rd_stable", bad_stable, 0);
      checkOutput("rd_last", bad_last, 0);
      checkOutput("done_pulses", done_cnt, 1);
      checkOutput("run_error", o_error, 0);
      checkOutput("run_busy", o_busy, 0);
      checkOutput("run_qbit", q_qbit_num, qbit);
      prev_qbit = qbit;
      $display("[TB] legal run qbit=%0d ins=%0d exec=%0d finished", qbit, ins, exec);
   endtask

   task automatic runIllegal(input int qbit, input int ins);
      activity = 0;
      done_cnt = 0;
      applyStimulus(qbit, ins);
      for (int c = 0; c < 20 && done_cnt == 0; c++) @(negedge clk);
      repeat (2) @(negedge clk);
      checkOutput("ill_done", done_cnt, 1);
      checkOutput("ill_error", o_error, 1);
      checkOutput("ill_activity", activity, 0);
      checkOutput("ill_busy", o_busy, 0);
      checkOutput("ill_qbit", q_qbit_num, prev_qbit);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"}, o_busy, 0);
      checkOutput({tag, "_qea_en"}, {q_ctx_en, q_ctx_wea, q_state_ena, q_state_wea, q_start}, 0);
      checkOutput({tag, "_addr"}, {q_ctx_addr, q_state_addra}, 0);
      checkOutput({tag, "_status"}, {o_done, o_error, o_rd_valid, o_rd_last, o_ctx_ready}, 0);
      checkOutput({tag, "_exec"}, o_exec_cycles, 0);
      checkOutput({tag, "_qbit"}, q_qbit_num, 0);
      checkOutput({tag, "_dina"}, q_state_dina, 0);
      checkOutput({tag, "_rd_data"}, o_rd_data, 0);
      checkOutput({tag, "_ctx_data"}, q_ctx_data, 0);
   endtask

   initial begin
      int acc;
      rst_n = 1'b0; i_run = 1'b0; i_qbit_num = '0; i_ins_num = '0;
      i_ctx_valid = 1'b0; i_ctx_word = '0; i_rd_ready = 1'b0;
      repeat (3) @(negedge clk);
      checkAllZero("rst");
      rst_n = 1'b1;

      runLegal(11, 153, 1000, 100, 100);
      runIllegal(2, 10);
      runIllegal(6, 0);
      runIllegal(19, 5);
      runLegal(4, 20, 37, 60, 50);
      runLegal(3, 1, 1, 70, 40);
      runLegal(7, 60, 250, 50, 30);

      // Abandon a run partway through state initialisation
      clearRun(11, 5, 1000);
      applyStimulus(11, 5);
      feedCtx(5, 100, acc);
      for (int c = 0; c < 1000 && init_writes < 100; c++) @(negedge clk);
      checkOutput("rstmid_reach", init_writes, 100);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkAllZero("rstmid");
      @(negedge clk);
      rst_n = 1'b1;
      prev_qbit = 0;
      runLegal(5, 9, 12, 80, 60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
